// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: accepts one exception, interrupt or mret in IDLE,
// then writes mepc/mcause/mtval/mstatus (or mstatus only) and issues a PC redirect.
module trap_ctrl #(
    parameter int unsigned CSR_ADDR_WIDTH = 12,
    parameter int unsigned RDATA_WIDTH    = 32
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      exc_req_in,
    input  logic [3:0]                exc_code_in,
    input  logic [RDATA_WIDTH-1:0]    exc_tval_in,
    input  logic [RDATA_WIDTH-1:0]    exc_pc_in,
    input  logic                      mret_req_in,
    input  logic                      meip_in,
    input  logic                      msip_in,
    input  logic                      mtip_in,
    input  logic [RDATA_WIDTH-1:0]    mstatus_in,
    input  logic [RDATA_WIDTH-1:0]    mie_in,
    input  logic [RDATA_WIDTH-1:0]    mtvec_in,
    input  logic [RDATA_WIDTH-1:0]    mepc_in,
    output logic                      exc_ack_out,
    output logic                      irq_ack_out,
    output logic                      mret_ack_out,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_out,
    output logic [RDATA_WIDTH-1:0]    csr_wdata_out,
    output logic                      csr_we_out,
    output logic                      redirect_valid_out,
    output logic [RDATA_WIDTH-1:0]    redirect_pc_out,
    output logic                      busy_out
);
    localparam int unsigned W = RDATA_WIDTH;
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMstatus = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMepc    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMcause  = CSR_ADDR_WIDTH'(12'h342);
    localparam logic [CSR_ADDR_WIDTH-1:0] AddrMtval   = CSR_ADDR_WIDTH'(12'h343);

    typedef enum logic [2:0] {
        StIdle, StWrMepc, StWrMcause, StWrMtval, StWrMstatus, StMretMstatus, StRedirect
    } state_e;

    state_e         state_q;
    logic [W-1:0]   pc_q, cause_q, tval_q, mstatus_q, mtvec_q, mepc_q;

    logic           idle, irq_mei, irq_msi, irq_mti, irq_any;
    logic           take_exc, take_irq, take_mret;
    logic [3:0]     irq_code;
    logic [W-1:0]   cap_pc, cap_cause, cap_tval;
    logic [W-1:0]   trap_base, trap_target, mret_target;
    logic           unused_mie, unused_cause;

    function automatic logic [W-1:0] trap_mstatus(input logic [W-1:0] m);
        logic [W-1:0] r;
        r        = m;
        r[7]     = m[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [W-1:0] mret_mstatus(input logic [W-1:0] m);
        logic [W-1:0] r;
        r        = m;
        r[3]     = m[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Acks are suppressed while reset is asserted since the accept edge would be discarded.
    assign idle      = (state_q == StIdle) && reset_in;
    assign irq_mei   = mstatus_in[3] & mie_in[11] & meip_in;
    assign irq_msi   = mstatus_in[3] & mie_in[3]  & msip_in;
    assign irq_mti   = mstatus_in[3] & mie_in[7]  & mtip_in;
    assign irq_any   = irq_mei | irq_msi | irq_mti;
    assign take_exc  = idle & exc_req_in;
    assign take_irq  = idle & ~exc_req_in & irq_any;
    assign take_mret = idle & ~exc_req_in & ~irq_any & mret_req_in;

    assign exc_ack_out  = take_exc;
    assign irq_ack_out  = take_irq;
    assign mret_ack_out = take_mret;
    assign busy_out     = (state_q != StIdle);

    assign irq_code  = irq_mei ? 4'd11 : (irq_msi ? 4'd3 : 4'd7);
    assign cap_pc    = take_irq ? exc_pc_in + W'(4) : exc_pc_in;
    assign cap_cause = take_irq ? {1'b1, {(W-5){1'b0}}, irq_code}
                                : {1'b0, {(W-5){1'b0}}, exc_code_in};
    assign cap_tval  = take_irq ? '0 : exc_tval_in;

    assign trap_base   = mtvec_q & ~W'(3);
    assign trap_target = (mtvec_q[1:0] == 2'b01 && cause_q[W-1])
                         ? trap_base + W'({cause_q[3:0], 2'b00}) : trap_base;
    assign mret_target = mepc_q & ~W'(3);

    assign unused_mie   = ^{mie_in[W-1:12], mie_in[10:8], mie_in[6:4], mie_in[2:0]};
    assign unused_cause = ^cause_q[W-2:4];

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q            <= StIdle;
            pc_q               <= '0;
            cause_q            <= '0;
            tval_q             <= '0;
            mstatus_q          <= '0;
            mtvec_q            <= '0;
            mepc_q             <= '0;
            csr_we_out         <= 1'b0;
            csr_waddr_out      <= '0;
            csr_wdata_out      <= '0;
            redirect_valid_out <= 1'b0;
            redirect_pc_out    <= '0;
        end else begin
            csr_we_out         <= 1'b0;
            csr_waddr_out      <= '0;
            csr_wdata_out      <= '0;
            redirect_valid_out <= 1'b0;
            redirect_pc_out    <= '0;
            unique case (state_q)
                StIdle: begin
                    if (take_exc || take_irq || take_mret) begin
                        pc_q      <= cap_pc;
                        cause_q   <= cap_cause;
                        tval_q    <= cap_tval;
                        mstatus_q <= mstatus_in;
                        mtvec_q   <= mtvec_in;
                        mepc_q    <= mepc_in;
                    end
                    if (take_exc || take_irq) begin
                        state_q       <= StWrMepc;
                        csr_we_out    <= 1'b1;
                        csr_waddr_out <= AddrMepc;
                        csr_wdata_out <= cap_pc & ~W'(3);
                    end else if (take_mret) begin
                        state_q       <= StMretMstatus;
                        csr_we_out    <= 1'b1;
                        csr_waddr_out <= AddrMstatus;
                        csr_wdata_out <= mret_mstatus(mstatus_in);
                    end
                end
                StWrMepc: begin
                    state_q       <= StWrMcause;
                    csr_we_out    <= 1'b1;
                    csr_waddr_out <= AddrMcause;
                    csr_wdata_out <= cause_q;
                end
                StWrMcause: begin
                    state_q       <= StWrMtval;
                    csr_we_out    <= 1'b1;
                    csr_waddr_out <= AddrMtval;
                    csr_wdata_out <= tval_q;
                end
                StWrMtval: begin
                    state_q       <= StWrMstatus;
                    csr_we_out    <= 1'b1;
                    csr_waddr_out <= AddrMstatus;
                    csr_wdata_out <= trap_mstatus(mstatus_q);
                end
                StWrMstatus: begin
                    state_q            <= StRedirect;
                    redirect_valid_out <= 1'b1;
                    redirect_pc_out    <= trap_target;
                end
                StMretMstatus: begin
                    state_q            <= StRedirect;
                    redirect_valid_out <= 1'b1;
                    redirect_pc_out    <= mret_target;
                end
                StRedirect: state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: drives and samples on the falling edge, checks with assertions.
module tb_trap_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        exc_req, mret_req, meip, msip, mtip;
    logic [3:0]  exc_code;
    logic [31:0] exc_tval, exc_pc, mstatus, mie, mtvec, mepc;
    logic        exc_ack, irq_ack, mret_ack, csr_we, rd_valid, busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, rd_pc;

    int total = 0;
    int bad   = 0;

    trap_ctrl #(.CSR_ADDR_WIDTH(12), .RDATA_WIDTH(32)) dut (
        .clk_in(clk), .reset_in(reset_n),
        .exc_req_in(exc_req), .exc_code_in(exc_code), .exc_tval_in(exc_tval),
        .exc_pc_in(exc_pc), .mret_req_in(mret_req),
        .meip_in(meip), .msip_in(msip), .mtip_in(mtip),
        .mstatus_in(mstatus), .mie_in(mie), .mtvec_in(mtvec), .mepc_in(mepc),
        .exc_ack_out(exc_ack), .irq_ack_out(irq_ack), .mret_ack_out(mret_ack),
        .csr_waddr_out(csr_waddr), .csr_wdata_out(csr_wdata), .csr_we_out(csr_we),
        .redirect_valid_out(rd_valid), .redirect_pc_out(rd_pc), .busy_out(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_req = 0; mret_req = 0; meip = 0; msip = 0; mtip = 0;
        exc_code = 0; exc_tval = 0; exc_pc = 0;
        mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    endtask

    task automatic chk_acks(input string tag, input logic [2:0] exp);
        chk(tag, {29'b0, exc_ack, irq_ack, mret_ack}, {29'b0, exp});
    endtask

    task automatic chk_csr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_we"}, {31'b0, csr_we}, 32'd1);
        chk({tag, "_addr"}, {20'b0, csr_waddr}, addr);
        chk({tag, "_data"}, csr_wdata, data);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_rdv"}, {31'b0, rd_valid}, 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_we"}, {31'b0, csr_we}, 32'd0);
        chk({tag, "_addr"}, {20'b0, csr_waddr}, 32'd0);
        chk({tag, "_data"}, csr_wdata, 32'd0);
        chk({tag, "_rdv"}, {31'b0, rd_valid}, 32'd0);
        chk({tag, "_rpc"}, rd_pc, 32'd0);
    endtask

    // Call at the accept cycle; scrambles inputs while busy to show they are ignored.
    task automatic run_trap(input string tag, input logic [31:0] w_mepc, input logic [31:0] w_cause,
                            input logic [31:0] w_tval, input logic [31:0] w_mst,
                            input logic [31:0] rpc);
        step();
        exc_req = 1; mret_req = 1; meip = 1; msip = 1; mtip = 1; mie = '1; mstatus = 32'h8;
        mtvec = 32'hFFFF_FFF1; mepc = 32'h5555_5555; exc_pc = 32'h1234_5678;
        exc_tval = 32'hCAFE_F00D; exc_code = 4'hF;
        #1;
        chk_acks({tag, "_busy_acks"}, 3'b000);
        chk_csr({tag, "_mepc"}, 32'h341, w_mepc);
        step();
        chk_csr({tag, "_mcause"}, 32'h342, w_cause);
        step();
        chk_csr({tag, "_mtval"}, 32'h343, w_tval);
        step();
        chk_csr({tag, "_mstatus"}, 32'h300, w_mst);
        step();
        chk({tag, "_rdv"}, {31'b0, rd_valid}, 32'd1);
        chk({tag, "_rpc"}, rd_pc, rpc);
        chk({tag, "_rd_we"}, {31'b0, csr_we}, 32'd0);
        chk({tag, "_rd_busy"}, {31'b0, busy}, 32'd1);
        chk_acks({tag, "_rd_acks"}, 3'b000);
        clear_inputs();
        step();
        chk_idle({tag, "_done"});
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        step();
        step();
        chk_idle("reset");
        chk_acks("reset_acks", 3'b000);
        reset_n = 1;
        step();
        chk_idle("post_reset");

        // Exception, direct mode
        exc_req = 1; exc_code = 4'd2; exc_tval = 32'hDEAD_BEEF; exc_pc = 32'h100;
        mtvec = 32'h8000; mstatus = 32'h8;
        #1;
        chk_acks("exc_ack", 3'b100);
        run_trap("exc", 32'h100, 32'h2, 32'hDEAD_BEEF, 32'h1880, 32'h8000);

        // Vectored timer interrupt
        mstatus = 32'h8; mie = 32'h80; mtip = 1; mtvec = 32'h8001; exc_pc = 32'h200;
        #1;
        chk_acks("mti_ack", 3'b010);
        run_trap("mti", 32'h204, 32'h8000_0007, 32'h0, 32'h1880, 32'h801C);

        // All pending: MEI wins; mtvec mode 3 is direct; PC+4 wraps
        mstatus = 32'h8; mie = 32'h888; meip = 1; msip = 1; mtip = 1;
        mtvec = 32'h8003; exc_pc = 32'hFFFF_FFFE; exc_tval = 32'h77;
        #1;
        chk_acks("mei_ack", 3'b010);
        run_trap("mei", 32'h0, 32'h8000_000B, 32'h0, 32'h1880, 32'h8000);

        // Software interrupt in vectored mode
        mstatus = 32'h88; mie = 32'h8; msip = 1; mtip = 1; mtvec = 32'h400_0001; exc_pc = 32'h10;
        #1;
        chk_acks("msi_ack", 3'b010);
        run_trap("msi", 32'h14, 32'h8000_0003, 32'h0, 32'h1880, 32'h400_000C);

        // Global disable masks interrupts
        mstatus = 32'h0; mie = 32'h888; meip = 1; msip = 1; mtip = 1;
        #1;
        chk_acks("mie_off_acks", 3'b000);
        step();
        chk_idle("mie_off");
        // Local enables all zero
        mstatus = 32'h8; mie = 32'h0;
        #1;
        chk_acks("mie_zero_acks", 3'b000);
        step();
        chk_idle("mie_zero");
        clear_inputs();

        // Mret
        mstatus = 32'h1880; mepc = 32'h104; mret_req = 1;
        #1;
        chk_acks("mret_ack", 3'b001);
        step();
        clear_inputs();
        #1;
        chk_csr("mret_mstatus", 32'h300, 32'h1888);
        step();
        chk("mret_rdv", {31'b0, rd_valid}, 32'd1);
        chk("mret_rpc", rd_pc, 32'h104);
        chk("mret_rd_we", {31'b0, csr_we}, 32'd0);
        step();
        chk_idle("mret_done");

        // Mret with MPIE=0, misaligned mepc
        mstatus = 32'h0000_0008; mepc = 32'h2003; mret_req = 1;
        #1;
        chk_acks("mret2_ack", 3'b001);
        step();
        clear_inputs();
        #1;
        chk_csr("mret2_mstatus", 32'h300, 32'h1880);
        step();
        chk("mret2_rpc", rd_pc, 32'h2000);
        clear_inputs();
        step();
        chk_idle("mret2_done");

        // Exception and mret together: exception wins
        exc_req = 1; mret_req = 1; exc_code = 4'd5; exc_tval = 32'h1234; exc_pc = 32'h300;
        mtvec = 32'h4000; mepc = 32'h999;
        #1;
        chk_acks("exc_mret_ack", 3'b100);
        run_trap("exc_mret", 32'h300, 32'h5, 32'h1234, 32'h1800, 32'h4000);

        // Reset abort during WR_MCAUSE
        exc_req = 1; exc_code = 4'd1; exc_pc = 32'h40; mtvec = 32'h100;
        #1;
        chk_acks("abort_ack", 3'b100);
        step();
        clear_inputs();
        #1;
        chk_csr("abort_mepc", 32'h341, 32'h40);
        step();
        chk_csr("abort_mcause", 32'h342, 32'h1);
        reset_n = 0;
        step();
        chk_idle("abort_rst");
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("abort_after");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameters: CSR_ADDR_WIDTH, default 12, CSR address width; RDATA_WIDTH, default 32, CSR data and PC width.
REQ-002 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset_in  input  1  reset, synchronous, active-low.
REQ-004 exc_req_in  input  1  exception request, held high until exc_ack_out.
REQ-005 exc_code_in  input  4  exception code; exc_tval_in  input  32  faulting address or instruction; exc_pc_in  input  32  PC of the faulting instruction or of the last retired instruction.
REQ-006 mret_req_in  input  1  mret request, held high until mret_ack_out.
REQ-007 meip_in, msip_in, mtip_in  input  1 each  machine external, software and timer interrupt pending, as levels.
REQ-008 mstatus_in, mie_in, mtvec_in, mepc_in  input  32 each  current CSR values.
REQ-009 exc_ack_out, irq_ack_out, mret_ack_out  output  1 each  accept pulses.
REQ-010 csr_waddr_out  output  12, csr_wdata_out  output  32, csr_we_out  output  1  CSR write port.
REQ-011 redirect_valid_out  output  1, redirect_pc_out  output  32  PC redirect.
REQ-012 busy_out  output  1  high while the FSM is not in IDLE; the pipeline holds while it is high.

Function
REQ-013 The FSM SHALL have these states: IDLE, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, MRET_MSTATUS, REDIRECT.
REQ-014 In IDLE, selection priority SHALL be, highest first:
- exc_req_in;
- an enabled interrupt, when mstatus_in[3]=1, in the order MEI (mie_in[11]&meip_in), MSI (mie_in[3]&msip_in), MTI (mie_in[7]&mtip_in);
- mret_req_in.
REQ-015 The ack for the selected request SHALL assert combinationally in that IDLE cycle only; all other acks SHALL be 0, and requests SHALL be ignored while busy_out=1.
REQ-016 On the accept edge, the block SHALL capture:
- the trap PC: exc_pc_in for an exception, exc_pc_in+4 (mod 2^32) for an interrupt;
- the cause: {1'b0,27'b0,exc_code_in} for an exception, {1'b1,27'b0,code} for an interrupt, with code 11, 3 or 7;
- the tval: exc_tval_in for an exception, 0 for an interrupt;
- mstatus_in, mtvec_in and mepc_in.
REQ-017 On that edge, a trap SHALL go to WR_MEPC and an mret SHALL go to MRET_MSTATUS.
REQ-018 Each WR_* and MRET_MSTATUS state SHALL last exactly one cycle, with csr_we_out=1 and:
- WR_MEPC: address 0x341, data = captured PC with bits [1:0] cleared;
- WR_MCAUSE: address 0x342, data = captured cause;
- WR_MTVAL: address 0x343, data = captured tval;
- WR_MSTATUS: address 0x300, data = captured mstatus with MPIE[7] set to MIE[3], MIE[3]=0, MPP[12:11]=2'b11;
- MRET_MSTATUS: address 0x300, data = captured mstatus with MIE[3] set to MPIE[7], MPIE[7]=1, MPP[12:11]=2'b11.
REQ-019 The state order SHALL be WR_MEPC->WR_MCAUSE->WR_MTVAL->WR_MSTATUS->REDIRECT for a trap, and MRET_MSTATUS->REDIRECT for an mret.
REQ-020 In REDIRECT, for one cycle, redirect_valid_out=1 and csr_we_out=0, then the next state SHALL be IDLE.
REQ-021 The redirect PC SHALL be:
- for a trap, base = {mtvec[31:2],2'b00};
- base + 4*code when mtvec[1:0]=2'b01 and the trap is an interrupt;
- otherwise base, with mtvec[1:0] of 2'b10 or 2'b11 treated as direct mode;
- for an mret, {mepc[31:2],2'b00}.
REQ-022 Latency from the accept cycle to redirect SHALL be 5 cycles for a trap and 2 cycles for an mret; a new request SHALL be acceptable in the cycle after REDIRECT.
REQ-023 Outside the write and REDIRECT states, csr_we_out, csr_waddr_out, csr_wdata_out, redirect_valid_out and redirect_pc_out SHALL be 0.
REQ-024 When exc_req_in and mret_req_in are high together, the exception SHALL be taken and mret_ack_out SHALL stay 0.
REQ-025 Input changes after the accept cycle SHALL NOT affect the sequence in progress.

Reset
REQ-026 While reset_in=0 at a rising edge, the next state SHALL be IDLE and all captured registers SHALL be 0.
REQ-027 After reset, all outputs SHALL be 0.
REQ-028 Reset mid-sequence SHALL abort the sequence with no further CSR write or redirect.

Verification
REQ-029 Exception sequence: exc_req_in=1, code=2, tval=0xDEADBEEF, pc=0x100, mtvec=0x8000, mstatus=0x8 -> exc_ack_out pulses, then these writes on successive cycles, then redirect_valid_out=1 with redirect_pc_out=0x8000, then busy_out=0:
- 0x341<-0x100;
- 0x342<-0x2;
- 0x343<-0xDEADBEEF;
- 0x300<-0x1880.
REQ-030 Vectored timer interrupt: mstatus=0x8, mie=0x80, mtip=1, mtvec=0x8001, pc=0x200 -> the following, with redirect_pc_out=0x801C:
- 0x341<-0x204;
- 0x342<-0x80000007;
- 0x343<-0.
REQ-031 Interrupt priority and masking, in three runs:
- meip, msip and mtip all set and all enabled -> cause 0x8000000B;
- mstatus[3]=0 -> no irq_ack_out;
- mie=0 -> no irq_ack_out.
REQ-032 Mret: mstatus=0x1880, mepc=0x104, mret_req_in=1 -> 0x300<-0x1888, next cycle redirect_pc_out=0x104; and exc_req_in with mret_req_in high together -> only exc_ack_out pulses.
REQ-033 Reset abort: reset_in=0 during WR_MCAUSE -> csr_we_out=0 and busy_out=0 from the next cycle, with no redirect.
